// File: rtl/sauria_pe_dot_pkg.sv
// sauria_pe_dot_pkg: shared widths, pipeline token and saturating accumulate for the dot-product PE.
// The token width is sized for the default lane configuration below.
package sauria_pe_dot_pkg;
    localparam int IA_W_DEF  = 8;
    localparam int IB_W_DEF  = 8;
    localparam int LANES_DEF = 2;
    localparam int LIDX_W    = (LANES_DEF > 1) ? $clog2(LANES_DEF) : 1;
    localparam int SUM_W     = IA_W_DEF + IB_W_DEF + $clog2(LANES_DEF) + ((LANES_DEF == 1) ? 1 : 0);

    typedef struct packed {
        logic signed [SUM_W-1:0] sum;
        logic                    valid;
        logic                    cswitch;
    } pe_tok_t;

    typedef struct packed {
        logic signed [63:0] result;
        logic               sat;
    } sat_res_t;

    // clamps acc + sum to the signed range of an oc_w-bit accumulator
    function automatic sat_res_t sat_add(input logic signed [63:0] acc, input logic signed [63:0] sum, input int oc_w);
        logic signed [63:0] hi, r;
        hi = (64'sd1 <<< (oc_w - 1)) - 64'sd1;
        r  = acc + sum;
        return '{result: (r > hi) ? hi : (r < ~hi) ? ~hi : r, sat: (r > hi) || (r < ~hi)};
    endfunction
endpackage

// File: rtl/sauria_pe_dot_if.sv
// sauria_pe_dot_if: operand, scan-chain and control bundle of one dot-product PE
interface sauria_pe_dot_if #(
    parameter int IA_W  = 8,
    parameter int IB_W  = 8,
    parameter int OC_W  = 24,
    parameter int LANES = 2,
    parameter int TH_W  = 2
);
    logic [LANES*IA_W-1:0] i_a, o_a;
    logic [LANES*IB_W-1:0] i_b, o_b;
    logic [OC_W-1:0]       i_c, o_c;
    logic                  i_reg_clear, i_cell_en, i_cell_sc_en, i_pipeline_en, i_cswitch, i_cscan_en;
    logic [TH_W-1:0]       i_thres;
    logic                  o_cswitch, o_cell_en, o_sat, o_sc_lost;

    modport slave (
        input  i_a, i_b, i_c, i_reg_clear, i_cell_en, i_cell_sc_en, i_pipeline_en, i_cswitch, i_cscan_en, i_thres,
        output o_a, o_b, o_c, o_cswitch, o_cell_en, o_sat, o_sc_lost
    );
    modport master (
        output i_a, i_b, i_c, i_reg_clear, i_cell_en, i_cell_sc_en, i_pipeline_en, i_cswitch, i_cscan_en, i_thres,
        input  o_a, o_b, o_c, o_cswitch, o_cell_en, o_sat, o_sc_lost
    );
endinterface

// File: rtl/sauria_pe_dot_mul.sv
// sauria_pe_dot_mul: operand register, lane products, lane reduction and product pipeline.
// Small-operand lane gating is built only when SAURIA_PE_ZERO_GATING_EN is defined.
module sauria_pe_dot_mul
    import sauria_pe_dot_pkg::*;
#(
    parameter int IA_W       = IA_W_DEF,
    parameter int IB_W       = IB_W_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int STAGES_MUL = 1,
    parameter int TH_W       = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [LANES*IA_W-1:0] i_a,
    input  logic [LANES*IB_W-1:0] i_b,
    input  logic                  i_cswitch,
    input  logic [TH_W-1:0]       i_thres,
    output pe_tok_t               o_tok
);
    localparam int PW = IA_W + IB_W;
    logic signed [IA_W-1:0]  a_q [LANES];
    logic signed [IB_W-1:0]  b_q [LANES];
    logic [LANES-1:0]        gate, gate_q;
    logic                    cs_q, v_q;
    logic signed [SUM_W-1:0] sum;
    pe_tok_t                 tok0;

`ifdef SAURIA_PE_ZERO_GATING_EN
    // a lane is gated when either operand magnitude is below 2^i_thres
    for (genvar l = 0; l < LANES; l++) begin : g_gate
        logic [IA_W:0] sa, ma;
        logic [IB_W:0] sb, mb;
        assign sa      = {i_a[l*IA_W+IA_W-1], i_a[l*IA_W +: IA_W]};
        assign sb      = {i_b[l*IB_W+IB_W-1], i_b[l*IB_W +: IB_W]};
        assign ma      = sa[IA_W] ? -sa : sa;
        assign mb      = sb[IB_W] ? -sb : sb;
        assign gate[l] = ((ma >> i_thres) == '0) || ((mb >> i_thres) == '0);
    end
    always_ff @(posedge i_clk)
        if (i_rst || i_clr) gate_q <= '0;
        else if (i_en) gate_q <= gate;
`else
    logic unused_thres;
    assign unused_thres = ^i_thres;
    assign gate         = '0;
    assign gate_q       = '0;
`endif

    // gated lanes keep their old operands so the multipliers do not toggle
    always_ff @(posedge i_clk)
        if (i_rst || i_clr) begin
            for (int l = 0; l < LANES; l++) begin
                a_q[l] <= '0;
                b_q[l] <= '0;
            end
            cs_q <= 1'b0;
            v_q  <= 1'b0;
        end else if (i_en) begin
            for (int l = 0; l < LANES; l++)
                if (!gate[l]) begin
                    a_q[l] <= i_a[l*IA_W +: IA_W];
                    b_q[l] <= i_b[l*IB_W +: IB_W];
                end
            cs_q <= i_cswitch;
            v_q  <= ~&gate;
        end

    always_comb begin
        sum = '0;
        for (int l = 0; l < LANES; l++)
            sum = sum + (gate_q[l] ? '0 : SUM_W'(PW'(a_q[l]) * PW'(b_q[l])));
    end

    assign tok0 = '{sum: sum, valid: v_q, cswitch: cs_q};

    if (STAGES_MUL == 0) begin : g_nopipe
        assign o_tok = tok0;
    end else begin : g_pipe
        pe_tok_t [STAGES_MUL-1:0] st;
        always_ff @(posedge i_clk)
            if (i_rst || i_clr) st <= '0;
            else if (i_en) begin
                st[0] <= tok0;
                for (int s = 1; s < STAGES_MUL; s++) st[s] <= st[s-1];
            end
        assign o_tok = st[STAGES_MUL-1];
    end
endmodule

// File: rtl/sauria_pe_dot.sv
// sauria_pe_dot: LANES-wide signed dot-product PE with saturating accumulator, forwarding and scan chain.
// Define SAURIA_PE_ZERO_GATING_EN to gate lanes whose operands fall below 2^i_thres.
module sauria_pe_dot
    import sauria_pe_dot_pkg::*;
#(
    parameter int IA_W       = IA_W_DEF,
    parameter int IB_W       = IB_W_DEF,
    parameter int OC_W       = 24,
    parameter int LANES      = LANES_DEF,
    parameter int STAGES_MUL = 1,
    parameter int TH_W       = 2
) (
    input logic            i_clk,
    input logic            i_rst,
    sauria_pe_dot_if.slave bus
);
    logic                   en, arr, unused_hi;
    pe_tok_t                tok;
    sat_res_t               nxt;
    logic signed [OC_W-1:0] acc;

    assign en  = bus.i_cell_en & bus.i_pipeline_en;
    assign arr = en & tok.cswitch;
    // a marker's own term opens the next context instead of closing the current one
    assign nxt       = sat_add(tok.cswitch ? 64'sd0 : 64'(acc), 64'($signed(tok.sum)), OC_W);
    assign unused_hi = ^nxt.result[63:OC_W];

    sauria_pe_dot_mul #(
        .IA_W(IA_W), .IB_W(IB_W), .LANES(LANES), .STAGES_MUL(STAGES_MUL), .TH_W(TH_W)
    ) u_mul (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(bus.i_reg_clear), .i_en(en),
        .i_a(bus.i_a), .i_b(bus.i_b), .i_cswitch(bus.i_cswitch), .i_thres(bus.i_thres),
        .o_tok(tok)
    );

    always_ff @(posedge i_clk)
        if (i_rst || bus.i_reg_clear) begin
            acc           <= '0;
            bus.o_a       <= '0;
            bus.o_b       <= '0;
            bus.o_c       <= '0;
            bus.o_cswitch <= 1'b0;
            bus.o_cell_en <= 1'b0;
            bus.o_sat     <= 1'b0;
            bus.o_sc_lost <= 1'b0;
        end else begin
            if (en) begin
                bus.o_a       <= bus.i_a;
                bus.o_b       <= bus.i_b;
                bus.o_cswitch <= bus.i_cswitch;
                if (tok.cswitch || tok.valid) begin
                    acc <= OC_W'(nxt.result);
                    if (nxt.sat) bus.o_sat <= 1'b1;
                end
            end
            // a context switch overrides a concurrent shift and drops the upstream value
            if (bus.i_pipeline_en && (bus.i_cscan_en || arr)) bus.o_c <= arr ? acc : bus.i_c;
            if (arr && bus.i_cscan_en) bus.o_sc_lost <= 1'b1;
            if (bus.i_cell_sc_en) bus.o_cell_en <= bus.i_cell_en;
        end
endmodule

// File: tb/tb_sauria_pe_dot.sv
// tb_sauria_pe_dot: directed scoreboard bench for sauria_pe_dot (LANES=2, 8x8 operands, one product stage).
// Expectations are queued with the edge they are due on; a monitor compares them #1 after each rising edge.
`timescale 1ns/1ps
module tb_sauria_pe_dot;
`ifdef SAURIA_PE_ZERO_GATING_EN
    localparam bit ZG = 1'b1;
`else
    localparam bit ZG = 1'b0;
`endif
    localparam int K_C = 0, K_SAT = 1, K_LOST = 2, K_A = 3, K_CS = 4, K_CEN = 5, K_C2 = 6, K_SAT2 = 7, K_A2 = 8;

    typedef struct {
        int    due;
        int    kind;
        int    val;
        string name;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
    exp_t q[$];
    int   cyc = 0, checks = 0, errors = 0;

    always #5 clk = ~clk;

    sauria_pe_dot_if #(.IA_W(8), .IB_W(8), .OC_W(24), .LANES(2), .TH_W(2)) bus ();
    sauria_pe_dot_if #(.IA_W(8), .IB_W(8), .OC_W(16), .LANES(2), .TH_W(2)) bus2 ();

    sauria_pe_dot #(.IA_W(8), .IB_W(8), .OC_W(24), .LANES(2), .STAGES_MUL(1), .TH_W(2))
        dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    sauria_pe_dot #(.IA_W(8), .IB_W(8), .OC_W(16), .LANES(2), .STAGES_MUL(1), .TH_W(2))
        dut2 (.i_clk(clk), .i_rst(rst2), .bus(bus2));

    function automatic int actual(input int kind);
        case (kind)
            K_C:     return int'($signed(bus.o_c));
            K_SAT:   return int'(bus.o_sat);
            K_LOST:  return int'(bus.o_sc_lost);
            K_A:     return int'(bus.o_a);
            K_CS:    return int'(bus.o_cswitch);
            K_CEN:   return int'(bus.o_cell_en);
            K_C2:    return int'($signed(bus2.o_c));
            K_SAT2:  return int'(bus2.o_sat);
            K_A2:    return int'(bus2.o_a);
            default: return -1;
        endcase
    endfunction

    function automatic int pack2(input int a1, input int a0);
        return ((a1 & 255) << 8) | (a0 & 255);
    endfunction

    task automatic compare(input exp_t e);
        int a;
        a = actual(e.kind);
        checks++;
        if (a != e.val) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", e.name, cyc, a, e.val);
        end
    endtask

    task automatic want(input string name, input int kind, input int n, input int val);
        q.push_back('{cyc + n, kind, val, name});
    endtask

    task automatic put(input int a0, input int a1, input int b0, input int b1, input bit cs);
        bus.i_a       = {8'(a1), 8'(a0)};
        bus.i_b       = {8'(b1), 8'(b0)};
        bus.i_cswitch = cs;
        @(negedge clk);
    endtask

    // marker with zero operands, then idle until the completed sum is on o_c
    task automatic flush(input string name, input int val);
        want(name, K_C, 3, val);
        put(0, 0, 0, 0, 1'b1);
        repeat (3) put(0, 0, 0, 0, 1'b0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].due <= cyc) begin
                compare(q[i]);
                q.delete(i);
            end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        {bus.i_a, bus.i_b, bus.i_c, bus.i_thres} = '0;
        {bus.i_reg_clear, bus.i_cell_sc_en, bus.i_cswitch, bus.i_cscan_en} = '0;
        bus.i_cell_en = 1'b1;
        bus.i_pipeline_en = 1'b1;
        {bus2.i_a, bus2.i_b, bus2.i_c, bus2.i_thres} = '0;
        {bus2.i_reg_clear, bus2.i_cell_sc_en, bus2.i_cswitch, bus2.i_cscan_en, bus2.i_cell_en} = '0;
        bus2.i_pipeline_en = 1'b1;
        @(negedge clk);
        want("rst_c", K_C, 1, 0);
        want("rst_sat", K_SAT, 1, 0);
        want("rst_lost", K_LOST, 1, 0);
        want("rst_a", K_A, 1, 0);
        want("rst_cs", K_CS, 1, 0);
        want("rst_cell_en", K_CEN, 1, 0);
        want("rst_c2", K_C2, 1, 0);
        @(negedge clk);
        rst  = 1'b0;
        rst2 = 1'b0;
        // saturation on the 16-bit instance, then clear
        bus2.i_cell_en = 1'b1;
        bus2.i_a = 16'h7F7F;
        bus2.i_b = 16'h7F7F;
        want("t2_first_no_sat", K_SAT2, 3, 0);
        @(negedge clk);
        want("t2_sat", K_SAT2, 3, 1);
        @(negedge clk);
        @(negedge clk);
        bus2.i_cswitch = 1'b1;
        want("t2_pinned", K_C2, 3, 32767);
        @(negedge clk);
        bus2.i_cswitch = 1'b0;
        repeat (2) @(negedge clk);
        bus2.i_reg_clear = 1'b1;
        want("t2_clr_c", K_C2, 1, 0);
        want("t2_clr_sat", K_SAT2, 1, 0);
        want("t2_clr_a", K_A2, 1, 0);
        @(negedge clk);
        bus2.i_reg_clear = 1'b0;
        bus2.i_cell_en = 1'b0;
        // basic context: three terms of 2
        bus.i_cell_sc_en = 1'b1;
        want("t1_cell_en", K_CEN, 1, 1);
        want("t1_oa", K_A, 1, pack2(-2, 3));
        put(3, -2, 4, 5, 1'b0);
        bus.i_cell_sc_en = 1'b0;
        repeat (2) put(3, -2, 4, 5, 1'b0);
        want("t1_ocs", K_CS, 1, 1);
        flush("t1_c", 6);
        // pipeline stall mid-stream with a stray marker on the inputs
        repeat (2) put(3, -2, 4, 5, 1'b0);
        bus.i_pipeline_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            want("t4_oa_hold", K_A, 1, pack2(-2, 3));
            want("t4_oc_hold", K_C, 1, 6);
            put(9, 9, 9, 9, 1'b1);
        end
        bus.i_pipeline_en = 1'b1;
        put(3, -2, 4, 5, 1'b0);
        flush("t4_c", 6);
        // cell-enable stall: compute frozen, scan still shifts
        put(3, -2, 4, 5, 1'b0);
        bus.i_cell_en = 1'b0;
        bus.i_cscan_en = 1'b1;
        bus.i_c = 24'd77;
        want("t4b_scan", K_C, 1, 77);
        want("t4b_oa_hold", K_A, 1, pack2(-2, 3));
        want("t4b_no_lost", K_LOST, 1, 0);
        put(9, 9, 9, 9, 1'b1);
        bus.i_cscan_en = 1'b0;
        want("t4b_cell_en_hold", K_CEN, 1, 1);
        repeat (2) put(9, 9, 9, 9, 1'b1);
        bus.i_cell_en = 1'b1;
        repeat (2) put(3, -2, 4, 5, 1'b0);
        flush("t4b_c", 6);
        // zero gating thresholds
        bus.i_thres = 2'd2;
        put(3, 10, 7, 2, 1'b0);
        flush("t3_thres2", ZG ? 0 : 41);
        bus.i_thres = 2'd1;
        put(-1, -2, 5, 5, 1'b0);
        flush("t3_thres1", ZG ? -10 : -15);
        bus.i_thres = 2'd0;
        put(0, 5, 9, 3, 1'b0);
        flush("t3_thres0", 15);
        // scan shift colliding with a marker
        put(3, -2, 4, 5, 1'b0);
        put(0, 0, 0, 0, 1'b1);
        put(0, 0, 0, 0, 1'b0);
        bus.i_cscan_en = 1'b1;
        bus.i_c = 24'd99;
        want("t5_switch_wins", K_C, 1, 2);
        want("t5_lost", K_LOST, 1, 1);
        put(0, 0, 0, 0, 1'b0);
        bus.i_c = 24'd55;
        want("t5_next_shift", K_C, 1, 55);
        put(0, 0, 0, 0, 1'b0);
        bus.i_cscan_en = 1'b0;
        // reset in mid-accumulation
        repeat (2) put(3, -2, 4, 5, 1'b0);
        rst = 1'b1;
        want("t6_c", K_C, 1, 0);
        want("t6_a", K_A, 1, 0);
        want("t6_lost", K_LOST, 1, 0);
        want("t6_cell_en", K_CEN, 1, 0);
        put(3, -2, 4, 5, 1'b0);
        rst = 1'b0;
        put(1, 2, 1, 1, 1'b0);
        flush("t6_post_reset", 3);
        repeat (4) @(negedge clk);
        foreach (q[i]) begin
            errors++;
            $display("FAIL %s: got no comparison, expected one at edge %0d", q[i].name, q[i].due);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
